uart_fifo_ctrl: RTL and testbench
=================================

UART_FIFO_CTRL -- requirements
Module: uart_fifo_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 55000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division), CLKS_PER_BIT >= 4.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, TX and RX FIFO entries each, power of two, >= 2.
REQ-004 SHALL have parameter ADDR_DATA, default 32'hBFD003F8, data register address.
REQ-005 SHALL have parameter ADDR_STATE, default 32'hBFD003FC, status register address.
REQ-006 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port mem_addr  input  32  CPU access address.
REQ-009 SHALL have port mem_we  input  1  CPU write strobe, one access per cycle high.
REQ-010 SHALL have port mem_re  input  1  CPU read strobe, one access per cycle high.
REQ-011 SHALL have port CPU_send  input  32  write data; only [7:0] used for data, [3:2] for status clear.
REQ-012 SHALL have port CPU_receive  output  32  combinational read data.
REQ-013 SHALL have port rxd  input  1  serial receive line, asynchronous to clk.
REQ-014 SHALL have port txd  output  1  serial transmit line, registered.
REQ-015 SHALL have port stall_for_Uart_relate  output  1  pipeline stall request.

Function
REQ-016 Frame SHALL be 1 start (0), 8 data LSB first, optional parity (REQ-034), 1 stop (1); each bit CLKS_PER_BIT cycles.
REQ-017 Status word SHALL be {27'b0, perr, ferr, ovr, rx_nempty, tx_nfull}; bit0 TX FIFO not full, bit1 RX FIFO not empty, bit2 sticky overrun, bit3 sticky framing error, bit4 sticky parity error.
REQ-018 Read of ADDR_STATE (mem_re) SHALL return status combinationally; read of ADDR_DATA SHALL return {24'b0, RX head}, or 32'b0 if RX empty; any other case 32'b0.
REQ-019 Read of ADDR_DATA with RX non-empty SHALL pop RX FIFO at the clock edge ending the access; empty read pops nothing.
REQ-020 Write to ADDR_DATA with TX not full SHALL push CPU_send[7:0] at that edge; when TX full, no push and stall_for_Uart_relate=1 combinationally until a slot frees; CPU holds the access.
REQ-021 stall_for_Uart_relate SHALL be 0 in all other cases (no stall on reads).
REQ-022 Write to ADDR_STATE SHALL clear each sticky bit whose CPU_send bit (2,3,4) is 1; a same-cycle set event wins over clear.
REQ-023 FIFOs SHALL use wrapping pointers of log2(FIFO_DEPTH) bits plus a count of log2(FIFO_DEPTH)+1 bits; simultaneous push and pop SHALL leave count unchanged, both applied.
REQ-024 TX FSM states IDLE, START, DATA, [PARITY], STOP: in IDLE with TX non-empty, pop head and enter START next cycle; after STOP's CLKS_PER_BIT cycles return to IDLE, or START directly if non-empty (no idle gap); txd=1 in IDLE.
REQ-025 rxd SHALL pass a 2-flop synchronizer; RX FSM states IDLE, START, DATA, [PARITY], STOP.
REQ-026 RX IDLE->START on synchronized falling edge; sample at CLKS_PER_BIT/2; if start sample is 1, return to IDLE (glitch reject); subsequent samples every CLKS_PER_BIT.
REQ-027 Stop sample 0 SHALL set ferr and discard byte; stop sample 1 SHALL push byte into RX FIFO in the stop-sample cycle, then IDLE.
REQ-028 Push into full RX FIFO SHALL drop byte and set ovr, unless CPU pops in the same cycle, in which case byte is accepted and ovr unchanged.
REQ-029 RX FSM SHALL wait for stop sample before re-arming; no start detection during a frame.

Reset
REQ-030 On rst high, immediately: both FIFOs empty, pointers/counts 0, both FSMs IDLE, bit counters 0, sticky bits 0, txd=1, synchronizer flops 1.
REQ-031 Reset mid-frame SHALL abort the frame; the partial TX byte is lost; txd returns to 1 without waiting for clk.
REQ-032 After rst release, CPU_receive reads status as 32'h00000001.

Configuration
REQ-033 Macro UART_PARITY_EN SHALL select parity support at compile time.
REQ-034 With UART_PARITY_EN defined: even parity bit after data on TX; RX checks it, mismatch sets perr and discards byte (ferr checked too; both may set).
REQ-035 Without UART_PARITY_EN: no PARITY state, 10-bit frame, perr bit reads 0 and clear is ignored.

Verification (CLK_FREQ=160, BAUD=10, FIFO_DEPTH=4, macro undefined unless stated)
REQ-036 Write 8'hA5 to ADDR_DATA -> txd low 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, then high; status bit0=1 throughout.
REQ-037 Five back-to-back writes while first frame sends -> writes 1-4 accepted, write 5 stalls until first pop, frames contiguous with no idle gap.
REQ-038 Drive 8'h3C on rxd -> status 32'h3 after stop sample; ADDR_DATA read returns 32'h3C; next status 32'h1.
REQ-039 Five received bytes, no reads -> fifth dropped, status 32'h7; write 32'h4 to ADDR_STATE -> status 32'h3; four reads return bytes 1-4 in order.
REQ-040 Stop bit driven 0 -> ferr set, RX empty; 4-cycle low glitch on rxd -> no frame, status unchanged.
REQ-041 With UART_PARITY_EN: 8'h01 sent with parity 0 -> perr set, byte discarded; TX of 8'h03 emits parity 0.

Source files
------------

// File: rtl/uart_fifo_ctrl.sv
// rtl/uart_fifo_ctrl.sv - memory-mapped UART with TX/RX FIFOs, sticky status and CPU stall.
// Optional even parity is compiled in with `define UART_PARITY_EN.
module uart_fifo_ctrl #(
    parameter int          CLK_FREQ   = 55000000,
    parameter int          BAUD       = 9600,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] ADDR_DATA  = 32'hBFD003F8,
    parameter logic [31:0] ADDR_STATE = 32'hBFD003FC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic        mem_we,
    input  logic        mem_re,
    input  logic [31:0] CPU_send,
    output logic [31:0] CPU_receive,
    input  logic        rxd,
    output logic        txd,
    output logic        stall_for_Uart_relate
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} uart_state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;
`endif

    logic rd_data, rd_state, wr_data, wr_state;
    assign rd_data  = mem_re && (mem_addr == ADDR_DATA);
    assign rd_state = mem_re && (mem_addr == ADDR_STATE);
    assign wr_data  = mem_we && (mem_addr == ADDR_DATA);
    assign wr_state = mem_we && (mem_addr == ADDR_STATE);

    logic unused_cpu_send;
    assign unused_cpu_send = ^CPU_send[31:8];

    // ---------------- TX FIFO ----------------
    logic [7:0]       tx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [PTR_W:0]   tx_count;
    logic             tx_full, tx_empty, tx_push, tx_pop;

    assign tx_full  = (tx_count == FIFO_FULL);
    assign tx_empty = (tx_count == '0);
    assign tx_push  = wr_data && !tx_full;
    assign stall_for_Uart_relate = wr_data && tx_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_W'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_W'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + (PTR_W + 1)'(1);
                2'b01:   tx_count <= tx_count - (PTR_W + 1)'(1);
                default: tx_count <= tx_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= CPU_send[7:0];
    end

    // ---------------- TX FSM ----------------
    uart_state_t      tx_state, tx_state_n;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]       tx_bit, tx_bit_n;
    logic [7:0]       tx_shift, tx_shift_n;
    logic             txd_n, tx_cnt_done;
`ifdef UART_PARITY_EN
    logic             tx_par, tx_par_n;
`endif

    assign tx_cnt_done = (tx_cnt == BIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            txd      <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            txd      <= txd_n;
`ifdef UART_PARITY_EN
            tx_par   <= tx_par_n;
`endif
        end
    end

    // txd is registered alongside the state, so it changes on the same edge the state does.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + CNT_W'(1);
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        txd_n      = txd;
        tx_pop     = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_n   = tx_par;
`endif
        case (tx_state)
            ST_IDLE: begin
                tx_cnt_n = '0;
                txd_n    = 1'b1;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = tx_mem[tx_rd_ptr];
`ifdef UART_PARITY_EN
                    tx_par_n   = ^tx_mem[tx_rd_ptr];
`endif
                    tx_state_n = ST_START;
                    txd_n      = 1'b0;
                end
            end
            ST_START: begin
                if (tx_cnt_done) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    tx_state_n = ST_DATA;
                    txd_n      = tx_shift[0];
                end
            end
            ST_DATA: begin
                if (tx_cnt_done) begin
                    tx_cnt_n = '0;
                    if (tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                        tx_state_n = ST_PARITY;
                        txd_n      = tx_par;
`else
                        tx_state_n = ST_STOP;
                        txd_n      = 1'b1;
`endif
                    end else begin
                        tx_bit_n   = tx_bit + 3'd1;
                        tx_shift_n = {1'b0, tx_shift[7:1]};
                        txd_n      = tx_shift[1];
                    end
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (tx_cnt_done) begin
                    tx_cnt_n   = '0;
                    tx_state_n = ST_STOP;
                    txd_n      = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (tx_cnt_done) begin
                    tx_cnt_n = '0;
                    // Chain straight into the next frame so queued bytes leave without an idle gap.
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_n = tx_mem[tx_rd_ptr];
`ifdef UART_PARITY_EN
                        tx_par_n   = ^tx_mem[tx_rd_ptr];
`endif
                        tx_state_n = ST_START;
                        txd_n      = 1'b0;
                    end else begin
                        tx_state_n = ST_IDLE;
                        txd_n      = 1'b1;
                    end
                end
            end
            default: begin
                tx_state_n = ST_IDLE;
                tx_cnt_n   = '0;
                txd_n      = 1'b1;
            end
        endcase
    end

    // ---------------- RX synchronizer ----------------
    logic rxd_meta, rxd_sync, rxd_prev, rx_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    assign rx_fall = rxd_prev && !rxd_sync;

    // ---------------- RX FSM ----------------
    uart_state_t      rx_state, rx_state_n;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]       rx_bit, rx_bit_n;
    logic [7:0]       rx_shift, rx_shift_n;
    logic             rx_push, ferr_set, perr_set, rx_cnt_done;
`ifdef UART_PARITY_EN
    logic             rx_par_bad, rx_par_bad_n;
`endif

    assign rx_cnt_done = (rx_cnt == BIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
`ifdef UART_PARITY_EN
            rx_par_bad <= 1'b0;
`endif
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
`ifdef UART_PARITY_EN
            rx_par_bad <= rx_par_bad_n;
`endif
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + CNT_W'(1);
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_push    = 1'b0;
        ferr_set   = 1'b0;
        perr_set   = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_bad_n = rx_par_bad;
`endif
        case (rx_state)
            ST_IDLE: begin
                rx_cnt_n = '0;
                if (rx_fall) rx_state_n = ST_START;
            end
            ST_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rxd_sync ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_cnt_done) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rxd_sync, rx_shift[7:1]};
                    if (rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                        rx_state_n = ST_PARITY;
`else
                        rx_state_n = ST_STOP;
`endif
                    end else begin
                        rx_bit_n = rx_bit + 3'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (rx_cnt_done) begin
                    rx_cnt_n     = '0;
                    rx_par_bad_n = rxd_sync ^ (^rx_shift);
                    rx_state_n   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (rx_cnt_done) begin
                    rx_cnt_n   = '0;
                    rx_state_n = ST_IDLE;
                    ferr_set   = !rxd_sync;
`ifdef UART_PARITY_EN
                    perr_set   = rx_par_bad;
                    rx_push    = rxd_sync && !rx_par_bad;
`else
                    rx_push    = rxd_sync;
`endif
                end
            end
            default: begin
                rx_state_n = ST_IDLE;
                rx_cnt_n   = '0;
            end
        endcase
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]       rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [PTR_W:0]   rx_count;
    logic             rx_full, rx_empty, rx_pop, rx_accept, ovr_set;

    assign rx_full   = (rx_count == FIFO_FULL);
    assign rx_empty  = (rx_count == '0);
    assign rx_pop    = rd_data && !rx_empty;
    // A CPU pop in the same cycle frees the head slot, so a full FIFO can still take the byte.
    assign rx_accept = rx_push && (!rx_full || rx_pop);
    assign ovr_set   = rx_push && rx_full && !rx_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_accept) rx_wr_ptr <= rx_wr_ptr + PTR_W'(1);
            if (rx_pop)    rx_rd_ptr <= rx_rd_ptr + PTR_W'(1);
            case ({rx_accept, rx_pop})
                2'b10:   rx_count <= rx_count + (PTR_W + 1)'(1);
                2'b01:   rx_count <= rx_count - (PTR_W + 1)'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rx_accept) rx_mem[rx_wr_ptr] <= rx_shift;
    end

    // ---------------- sticky status ----------------
    logic ovr, ferr, perr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            ovr  <= ovr_set  || (ovr  && !(wr_state && CPU_send[2]));
            ferr <= ferr_set || (ferr && !(wr_state && CPU_send[3]));
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) perr <= 1'b0;
        else     perr <= perr_set || (perr && !(wr_state && CPU_send[4]));
    end
`else
    logic unused_perr_set;
    assign unused_perr_set = perr_set;
    assign perr = 1'b0;
`endif

    logic [31:0] status;
    assign status = {27'b0, perr, ferr, ovr, !rx_empty, !tx_full};

    always_comb begin
        CPU_receive = 32'b0;
        if (rd_state)
            CPU_receive = status;
        else if (rd_data && !rx_empty)
            CPU_receive = {24'b0, rx_mem[rx_rd_ptr]};
    end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb/tb_uart_fifo_ctrl.sv - directed self-checking bench for uart_fifo_ctrl.
module tb_uart_fifo_ctrl;

    localparam int          CPB = 16;
    localparam logic [31:0] A_DATA  = 32'hBFD003F8;
    localparam logic [31:0] A_STATE = 32'hBFD003FC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_addr = '0;
    logic        mem_we = 1'b0;
    logic        mem_re = 1'b0;
    logic [31:0] CPU_send = '0;
    logic [31:0] CPU_receive;
    logic        rxd = 1'b1;
    logic        txd;
    logic        stall_for_Uart_relate;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_fifo_ctrl #(
        .CLK_FREQ(160), .BAUD(10), .FIFO_DEPTH(4),
        .ADDR_DATA(A_DATA), .ADDR_STATE(A_STATE)
    ) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
        .CPU_send(CPU_send), .CPU_receive(CPU_receive), .rxd(rxd), .txd(txd),
        .stall_for_Uart_relate(stall_for_Uart_relate)
    );

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data, output int stalls);
        mem_addr = addr;
        CPU_send = data;
        mem_we   = 1'b1;
        #1;
        stalls = 0;
        while (stall_for_Uart_relate && stalls < 1000) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (stalls >= 1000) begin
            tests++; fails++;
            $display("FAIL write_stall_timeout: stalled %0d cycles, required < 1000", stalls);
        end
        @(negedge clk);
        mem_we = 1'b0;
    endtask

    task automatic cpu_read(input logic [31:0] addr, output logic [31:0] d);
        mem_addr = addr;
        mem_re   = 1'b1;
        #1;
        d = CPU_receive;
        @(negedge clk);
        mem_re = 1'b0;
    endtask

    task automatic rx_send(input logic [7:0] b, input logic par, input logic stop);
        rxd = 1'b0;
        wait_neg(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_neg(CPB);
        end
`ifdef UART_PARITY_EN
        rxd = par;
        wait_neg(CPB);
`else
        if (par) rxd = 1'b1;
`endif
        rxd = stop;
        wait_neg(CPB);
        rxd = 1'b1;
        wait_neg(CPB);
    endtask

    task automatic get_tx_frame(output logic [7:0] d, output logic par, output logic next_low);
        int n = 0;
        d = '0; par = 1'b0; next_low = 1'b0;
        while (txd !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            tests++; fails++;
            $display("FAIL tx_frame_timeout: txd=%b, required a start bit", txd);
            return;
        end
        wait_neg(7);
        tests++;
        if (txd !== 1'b0) begin
            fails++;
            $display("FAIL tx_start_center: txd=%b, required 0", txd);
        end
        for (int i = 0; i < 8; i++) begin
            wait_neg(CPB);
            d[i] = txd;
        end
`ifdef UART_PARITY_EN
        wait_neg(CPB);
        par = txd;
`endif
        wait_neg(CPB);
        tests++;
        if (txd !== 1'b1) begin
            fails++;
            $display("FAIL tx_stop_bit: txd=%b, required 1", txd);
        end
        wait_neg(9);
        next_low = (txd === 1'b0);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        wait_neg(2);
        tests++;
        if (txd !== 1'b1) begin fails++; $display("FAIL reset_txd: got %b, required 1", txd); end
        tests++;
        if (stall_for_Uart_relate !== 1'b0) begin
            fails++; $display("FAIL reset_stall: got %b, required 0", stall_for_Uart_relate);
        end
        rst = 1'b0;
        wait_neg(1);
        cpu_read(A_STATE, d);
        tests++;
        if (d !== 32'h1) begin fails++; $display("FAIL reset_status: got %h, required 00000001", d); end
        cpu_read(A_DATA, d);
        tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL empty_data_read: got %h, required 00000000", d); end
        cpu_read(32'h0000_0010, d);
        tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL other_addr_read: got %h, required 00000000", d); end
        mem_addr = A_STATE;
        #1;
        tests++;
        if (CPU_receive !== 32'h0) begin
            fails++; $display("FAIL no_strobe_read: got %h, required 00000000", CPU_receive);
        end
        wait_neg(1);
    endtask

    task automatic test_tx_single();
        logic [7:0] exp = 8'hA5;
        int stalls, n;
        cpu_write(A_DATA, 32'h0000_00A5, stalls);
        tests++;
        if (stalls != 0) begin fails++; $display("FAIL tx_single_stall: got %0d, required 0", stalls); end
        mem_addr = A_STATE;
        mem_re   = 1'b1;
        n = 0;
        while (txd !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        n = 0;
        while (txd === 1'b0 && n < 100) begin @(negedge clk); n++; end
        tests++;
        if (n != CPB) begin fails++; $display("FAIL tx_start_length: got %0d cycles, required 16", n); end
        wait_neg(7);
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (txd !== exp[i]) begin
                fails++; $display("FAIL tx_a5_bit%0d: got %b, required %b", i, txd, exp[i]);
            end
            tests++;
            if (CPU_receive[0] !== 1'b1) begin
                fails++; $display("FAIL tx_nfull_during_frame: got %b, required 1", CPU_receive[0]);
            end
            wait_neg(CPB);
        end
`ifdef UART_PARITY_EN
        tests++;
        if (txd !== 1'b0) begin fails++; $display("FAIL tx_a5_parity: got %b, required 0", txd); end
        wait_neg(CPB);
`endif
        tests++;
        if (txd !== 1'b1) begin fails++; $display("FAIL tx_a5_stop: got %b, required 1", txd); end
        wait_neg(40);
        tests++;
        if (txd !== 1'b1) begin fails++; $display("FAIL tx_idle_high: got %b, required 1", txd); end
        mem_re = 1'b0;
        wait_neg(1);
    endtask

    task automatic test_back_to_back();
        int st [6];
        logic [7:0] d, exp_b;
        logic par, next_low, exp_low;
        cpu_write(A_DATA, 32'h10, st[0]);
        wait_neg(3);
        for (int k = 1; k <= 5; k++) cpu_write(A_DATA, 32'h10 + k, st[k]);
        for (int k = 1; k <= 4; k++) begin
            tests++;
            if (st[k] != 0) begin fails++; $display("FAIL b2b_write%0d_stall: got %0d, required 0", k, st[k]); end
        end
        tests++;
        if (st[5] == 0) begin fails++; $display("FAIL b2b_write5_stall: got 0 cycles, required > 0"); end
        for (int k = 1; k <= 5; k++) begin
            get_tx_frame(d, par, next_low);
            exp_b = 8'h10 + 8'(k);
            exp_low = (k < 5);
            tests++;
            if (d !== exp_b) begin fails++; $display("FAIL b2b_frame%0d_data: got %h, required %h", k, d, exp_b); end
            tests++;
            if (next_low !== exp_low) begin
                fails++; $display("FAIL b2b_frame%0d_gap: next_start=%b, required %b", k, next_low, exp_low);
            end
        end
        wait_neg(20);
    endtask

    task automatic test_rx_single();
        logic [31:0] d;
        rx_send(8'h3C, ^8'h3C, 1'b1);
        cpu_read(A_STATE, d);
        tests++;
        if (d !== 32'h3) begin fails++; $display("FAIL rx_status_after_byte: got %h, required 00000003", d); end
        cpu_read(A_DATA, d);
        tests++;
        if (d !== 32'h3C) begin fails++; $display("FAIL rx_data_3c: got %h, required 0000003c", d); end
        cpu_read(A_STATE, d);
        tests++;
        if (d !== 32'h1) begin fails++; $display("FAIL rx_status_after_pop: got %h, required 00000001", d); end
    endtask

    task automatic test_rx_overrun();
        logic [31:0] d;
        logic [7:0] b;
        int stalls;
        for (int k = 1; k <= 5; k++) begin
            b = 8'(k * 8'h11);
            rx_send(b, ^b, 1'b1);
        end
        cpu_read(A_STATE, d);
        tests++;
        if (d !== 32'h7) begin fails++; $display("FAIL ovr_status: got %h, required 00000007", d); end
        cpu_write(A_STATE, 32'h4, stalls);
        cpu_read(A_STATE, d);
        tests++;
        if (d !== 32'h3) begin fails++; $display("FAIL ovr_clear: got %h, required 00000003", d); end
        for (int k = 1; k <= 4; k++) begin
            cpu_read(A_DATA, d);
            tests++;
            if (d !== 32'(k * 32'h11)) begin
                fails++; $display("FAIL ovr_read%0d: got %h, required %h", k, d, 32'(k * 32'h11));
            end
        end
        cpu_read(A_STATE, d);
        tests++;
        if (d !== 32'h1) begin fails++; $display("FAIL ovr_drained: got %h, required 00000001", d); end
    endtask

    task automatic test_rx_errors();
        logic [31:0] d;
        int stalls;
        rx_send(8'h81, ^8'h81, 1'b0);
        cpu_read(A_STATE, d);
        tests++;
        if (d !== 32'h9) begin fails++; $display("FAIL ferr_status: got %h, required 00000009", d); end
        cpu_write(A_STATE, 32'h8, stalls);
        cpu_read(A_STATE, d);
        tests++;
        if (d !== 32'h1) begin fails++; $display("FAIL ferr_clear: got %h, required 00000001", d); end
        rxd = 1'b0;
        wait_neg(4);
        rxd = 1'b1;
        wait_neg(300);
        cpu_read(A_STATE, d);
        tests++;
        if (d !== 32'h1) begin fails++; $display("FAIL glitch_status: got %h, required 00000001", d); end
        rx_send(8'h5A, ^8'h5A, 1'b1);
        cpu_read(A_DATA, d);
        tests++;
        if (d !== 32'h5A) begin fails++; $display("FAIL rx_after_glitch: got %h, required 0000005a", d); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        int stalls, lows, n;
        cpu_write(A_DATA, 32'h00, stalls);
        cpu_write(A_DATA, 32'h55, stalls);
        n = 0;
        while (txd !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        wait_neg(40);
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (txd !== 1'b1) begin fails++; $display("FAIL async_reset_txd: got %b, required 1", txd); end
        wait_neg(2);
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (txd === 1'b0) lows++;
        end
        tests++;
        if (lows != 0) begin fails++; $display("FAIL reset_flushes_tx: got %0d low cycles, required 0", lows); end
        cpu_read(A_STATE, d);
        tests++;
        if (d !== 32'h1) begin fails++; $display("FAIL status_after_reset: got %h, required 00000001", d); end
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        logic [31:0] d;
        logic [7:0] b;
        logic par, next_low;
        int stalls;
        rx_send(8'h01, 1'b0, 1'b1);
        cpu_read(A_STATE, d);
        tests++;
        if (d !== 32'h11) begin fails++; $display("FAIL perr_status: got %h, required 00000011", d); end
        cpu_write(A_STATE, 32'h10, stalls);
        cpu_read(A_STATE, d);
        tests++;
        if (d !== 32'h1) begin fails++; $display("FAIL perr_clear: got %h, required 00000001", d); end
        cpu_write(A_DATA, 32'h03, stalls);
        get_tx_frame(b, par, next_low);
        tests++;
        if (b !== 8'h03) begin fails++; $display("FAIL tx_parity_data: got %h, required 03", b); end
        tests++;
        if (par !== 1'b0) begin fails++; $display("FAIL tx_parity_bit: got %b, required 0", par); end
    endtask
`endif

    initial begin
        test_reset();
        test_tx_single();
        test_back_to_back();
        test_rx_single();
        test_rx_overrun();
        test_rx_errors();
        test_reset_midframe();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
